fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR engine controller. It accepts one input sample per handshake and stores it in a circular sample buffer. It then steps an external single-port coefficient ROM (read latency 1) through all taps while driving a single multiply-accumulate pipeline, and presents a rounded, saturated result with a valid/ready handshake. It replaces the fully parallel tap chain where DSP count matters more than throughput.

---
 rtl/fir_mac_sequencer_pkg.sv | 22 ++
 rtl/fir_sample_buffer.sv | 55 +++++
 rtl/fir_mac_sequencer.sv | 155 +++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared definitions for the time-multiplexed FIR engine: FSM states and width helpers.
package fir_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_e;

  // Coefficient/sample, product and accumulate stages to flush after the last tap.
  localparam int unsigned DRAIN_CYCLES = 3;

  function automatic int unsigned fir_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned fir_acc_width(input int unsigned dw, input int unsigned depth);
    return 2 * dw + $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_sample_buffer.sv
// Circular history of the last FIR_DEPTH samples with a registered tap-indexed read port.
module fir_sample_buffer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIR_DEPTH  = 16,
  localparam int unsigned ADDR_WIDTH = fir_addr_width(FIR_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_wr,
  input  logic signed [DATA_WIDTH-1:0] iv_wr_data,
  input  logic                         i_rd,
  input  logic        [ADDR_WIDTH-1:0] iv_tap,
  output logic signed [DATA_WIDTH-1:0] ov_rd_data
);

  localparam int unsigned EXT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FIR_DEPTH - 1);

  logic signed [DATA_WIDTH-1:0] mem [FIR_DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] nw;
  logic [ADDR_WIDTH-1:0] rd_idx_c;

  // (nw - k) mod FIR_DEPTH without relying on power-of-two wrap.
  always_comb begin
    rd_idx_c = nw - iv_tap;
    if (iv_tap > nw) begin
      rd_idx_c = ADDR_WIDTH'(EXT_WIDTH'(nw) + EXT_WIDTH'(FIR_DEPTH) - EXT_WIDTH'(iv_tap));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIR_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp         <= '0;
      nw         <= '0;
      ov_rd_data <= '0;
    end else if (i_en) begin
      if (i_wr) begin
        mem[wp] <= iv_wr_data;
        nw      <= wp;
        wp      <= (wp == LAST_IDX) ? '0 : wp + ADDR_WIDTH'(1);
      end
      if (i_rd) begin
        ov_rd_data <= mem[rd_idx_c];
      end
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: one sample per handshake, taps stepped through a ROM and a single MAC,
// rounded/saturated result presented on a valid/ready output.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIR_DEPTH  = 16,
  parameter int unsigned COEF_FRAC  = 23,
  localparam int unsigned ADDR_WIDTH = fir_addr_width(FIR_DEPTH),
  localparam int unsigned ACC_WIDTH  = fir_acc_width(DATA_WIDTH, FIR_DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] iv_din,
  input  logic                         i_din_valid,
  output logic                         o_din_ready,
  output logic        [ADDR_WIDTH-1:0] ov_coef_addr,
  output logic                         o_coef_en,
  input  logic signed [DATA_WIDTH-1:0] iv_coef,
  output logic signed [DATA_WIDTH-1:0] ov_dout,
  output logic                         o_dout_sat,
  output logic                         o_dout_valid,
  input  logic                         i_dout_ready
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned RND_WIDTH  = ACC_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP   = ADDR_WIDTH'(FIR_DEPTH - 1);
  localparam logic [1:0]            LAST_DRAIN = 2'(DRAIN_CYCLES - 1);
  localparam logic signed [RND_WIDTH-1:0] SAT_MAX =
    {{(RND_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RND_WIDTH-1:0] SAT_MIN =
    {{(RND_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  fir_state_e state, state_next_c;
  logic [ADDR_WIDTH-1:0] tap_cnt;
  logic [1:0]            drain_cnt;
  logic accept_c, drain_last_c, done_exit_c;

  logic signed [DATA_WIDTH-1:0] smp_q;
  logic                         st1_vld, st1_first, st2_vld, st2_first;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic signed [RND_WIDTH-1:0]  rnd_c, sh_c;
  logic signed [DATA_WIDTH-1:0] dout_c;
  logic                         sat_c;

  assign o_din_ready  = i_en & ~i_rst & (state == ST_IDLE);
  assign o_coef_en    = i_en & (state == ST_RUN);
  assign ov_coef_addr = tap_cnt;

  always_comb begin
    state_next_c = state;
    accept_c     = 1'b0;
    drain_last_c = 1'b0;
    done_exit_c  = 1'b0;
    case (state)
      ST_IDLE: if (i_en && i_din_valid) begin
        accept_c     = 1'b1;
        state_next_c = ST_RUN;
      end
      ST_RUN: if (i_en && tap_cnt == LAST_TAP) state_next_c = ST_DRAIN;
      ST_DRAIN: if (i_en && drain_cnt == LAST_DRAIN) begin
        drain_last_c = 1'b1;
        state_next_c = ST_DONE;
      end
      ST_DONE: if (i_en && i_dout_ready) begin
        done_exit_c  = 1'b1;
        state_next_c = ST_IDLE;
      end
      default: state_next_c = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next_c;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tap_cnt   <= '0;
      drain_cnt <= '0;
    end else if (i_en) begin
      if (state == ST_RUN) tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + ADDR_WIDTH'(1);
      if (state == ST_DRAIN) drain_cnt <= drain_last_c ? 2'd0 : drain_cnt + 2'd1;
    end
  end

  fir_sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIR_DEPTH  (FIR_DEPTH)
  ) u_buf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_wr       (accept_c),
    .iv_wr_data (iv_din),
    .i_rd       (o_coef_en),
    .iv_tap     (tap_cnt),
    .ov_rd_data (smp_q)
  );

  // Stage 1 is ROM data + buffer read, stage 2 the product; the accumulator reloads on tap 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st1_vld   <= 1'b0;
      st1_first <= 1'b0;
      st2_vld   <= 1'b0;
      st2_first <= 1'b0;
      prod      <= '0;
      acc       <= '0;
    end else if (i_en) begin
      st1_vld   <= (state == ST_RUN);
      st1_first <= (tap_cnt == '0);
      prod      <= PROD_WIDTH'(iv_coef) * PROD_WIDTH'(smp_q);
      st2_vld   <= st1_vld;
      st2_first <= st1_first;
      if (st2_vld) acc <= st2_first ? ACC_WIDTH'(prod) : acc + ACC_WIDTH'(prod);
    end
  end

  always_comb begin
    rnd_c  = RND_WIDTH'(acc) + (RND_WIDTH'(1) << (COEF_FRAC - 1));
    sh_c   = rnd_c >>> COEF_FRAC;
    sat_c  = 1'b0;
    dout_c = sh_c[DATA_WIDTH-1:0];
    if (sh_c > SAT_MAX) begin
      sat_c  = 1'b1;
      dout_c = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sh_c < SAT_MIN) begin
      sat_c  = 1'b1;
      dout_c = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_dout      <= '0;
      o_dout_sat   <= 1'b0;
      o_dout_valid <= 1'b0;
    end else if (i_en) begin
      if (drain_last_c) begin
        ov_dout      <= dout_c;
        o_dout_sat   <= sat_c;
        o_dout_valid <= 1'b1;
      end else if (done_exit_c) begin
        o_dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: vector table, hand-written corner sequences and a random run
// checked against a plain-arithmetic convolution model.
module tb_fir_mac_sequencer;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CF    = 23;
  localparam int unsigned AW    = 2;
  localparam int          NVEC  = 18;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_en = 1'b0;
  logic [DW-1:0] iv_din = '0;
  logic          i_din_valid = 1'b0;
  logic          o_din_ready;
  logic [AW-1:0] ov_coef_addr;
  logic          o_coef_en;
  logic [DW-1:0] iv_coef = '0;
  logic [DW-1:0] ov_dout;
  logic          o_dout_sat;
  logic          o_dout_valid;
  logic          i_dout_ready = 1'b0;

  logic [DW-1:0] rom [DEPTH];
  longint        hist [DEPTH];
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    logic [DW-1:0] h0, h1, h2, h3, x, y;
    logic          sat;
  } vec_t;
  vec_t vt [NVEC];

  fir_mac_sequencer #(.DATA_WIDTH(DW), .FIR_DEPTH(DEPTH), .COEF_FRAC(CF)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .iv_din       (iv_din),
    .i_din_valid  (i_din_valid),
    .o_din_ready  (o_din_ready),
    .ov_coef_addr (ov_coef_addr),
    .o_coef_en    (o_coef_en),
    .iv_coef      (iv_coef),
    .ov_dout      (ov_dout),
    .o_dout_sat   (o_dout_sat),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready)
  );

  always #5 i_clk = ~i_clk;

  // Single-port coefficient ROM, read latency 1, output held while disabled.
  always @(posedge i_clk) if (o_coef_en) iv_coef <= rom[ov_coef_addr];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic void push_hist(input logic [DW-1:0] x);
    for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'($signed(x));
  endfunction

  function automatic void clear_hist();
    for (int k = 0; k < DEPTH; k++) hist[k] = 0;
  endfunction

  // y = round(sum h[k]*x[n-k] / 2^CF), clamped to the signed output range.
  function automatic void ref_out(output logic [DW-1:0] y, output logic s);
    longint sum = 0;
    for (int k = 0; k < DEPTH; k++) sum += longint'($signed(rom[k])) * hist[k];
    sum = (sum + (longint'(1) <<< (CF - 1))) >>> CF;
    if (sum > 64'sd8388607) begin
      y = 24'h7FFFFF; s = 1'b1;
    end else if (sum < -64'sd8388608) begin
      y = 24'h800000; s = 1'b1;
    end else begin
      y = DW'(sum); s = 1'b0;
    end
  endfunction

  task automatic send(input logic [DW-1:0] x, input int hold, input int stall_at,
                      input int stall_len, output logic [DW-1:0] y, output logic s);
    int budget;
    int lat;
    logic [DW-1:0] ey;
    logic es;
    iv_din = x;
    i_din_valid = 1'b1;
    budget = 0;
    while (!o_din_ready && budget < 50) begin
      step();
      budget++;
    end
    check("din_ready_idle", o_din_ready, 1);
    step();
    i_din_valid = 1'b0;
    iv_din = '0;
    push_hist(x);
    lat = 1;
    while (!o_dout_valid && lat < 60) begin
      if (stall_at > 0 && lat == stall_at) begin
        i_en = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          step();
          check("stall_coef_en", o_coef_en, 0);
        end
        lat += stall_len;
        i_en = 1'b1;
      end
      step();
      lat++;
    end
    check("valid_latency", lat, (stall_at > 0) ? 8 + stall_len : 8);
    ref_out(ey, es);
    y = ov_dout;
    s = o_dout_sat;
    check("dout_model", ov_dout, ey);
    check("sat_model", o_dout_sat, es);
    check("din_ready_done", o_din_ready, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_dout", ov_dout, ey);
      check("hold_valid", o_dout_valid, 1);
      check("hold_din_ready", o_din_ready, 0);
    end
    i_dout_ready = 1'b1;
    #1;
    check("din_ready_at_D", o_din_ready, 0);
    step();
    i_dout_ready = 1'b0;
    check("din_ready_at_D1", o_din_ready, 1);
    check("valid_after_exit", o_dout_valid, 0);
  endtask

  initial begin
    logic [DW-1:0] y;
    logic s;
    clear_hist();
    for (int k = 0; k < DEPTH; k++) rom[k] = '0;

    // Impulse / tap order.
    vt[0]  = '{24'h400000, 24'h200000, 24'h100000, 24'h080000, 24'h400000, 24'h200000, 1'b0};
    vt[1]  = '{24'h400000, 24'h200000, 24'h100000, 24'h080000, 24'h000000, 24'h100000, 1'b0};
    vt[2]  = '{24'h400000, 24'h200000, 24'h100000, 24'h080000, 24'h000000, 24'h080000, 1'b0};
    vt[3]  = '{24'h400000, 24'h200000, 24'h100000, 24'h080000, 24'h000000, 24'h040000, 1'b0};
    vt[4]  = '{24'h400000, 24'h200000, 24'h100000, 24'h080000, 24'h000000, 24'h000000, 1'b0};
    // Step response.
    vt[5]  = '{24'h200000, 24'h200000, 24'h200000, 24'h200000, 24'h100000, 24'h040000, 1'b0};
    vt[6]  = '{24'h200000, 24'h200000, 24'h200000, 24'h200000, 24'h100000, 24'h080000, 1'b0};
    vt[7]  = '{24'h200000, 24'h200000, 24'h200000, 24'h200000, 24'h100000, 24'h0C0000, 1'b0};
    vt[8]  = '{24'h200000, 24'h200000, 24'h200000, 24'h200000, 24'h100000, 24'h100000, 1'b0};
    vt[9]  = '{24'h200000, 24'h200000, 24'h200000, 24'h200000, 24'h100000, 24'h100000, 1'b0};
    // Positive then negative saturation.
    vt[10] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
    vt[11] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
    vt[12] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
    vt[13] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
    vt[14] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 1'b1};
    vt[15] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'hFFFFFE, 1'b0};
    vt[16] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h800000, 1'b1};
    vt[17] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h800000, 1'b1};

    // Reset state, with i_en already high.
    i_en = 1'b1;
    repeat (2) step();
    check("rst_dout", ov_dout, 0);
    check("rst_sat", o_dout_sat, 0);
    check("rst_valid", o_dout_valid, 0);
    check("rst_din_ready", o_din_ready, 0);
    check("rst_coef_addr", ov_coef_addr, 0);
    check("rst_coef_en", o_coef_en, 0);
    i_rst = 1'b0;
    step();
    check("idle_din_ready", o_din_ready, 1);

    for (int i = 0; i < NVEC; i++) begin
      rom[0] = vt[i].h0; rom[1] = vt[i].h1; rom[2] = vt[i].h2; rom[3] = vt[i].h3;
      send(vt[i].x, i % 3, 0, 0, y, s);
      check("tbl_dout", y, vt[i].y);
      check("tbl_sat", s, vt[i].sat);
    end

    // Backpressure for 10 cycles in DONE.
    rom[0] = 24'h400000; rom[1] = 24'h200000; rom[2] = 24'h100000; rom[3] = 24'h080000;
    send(24'h123456, 10, 0, 0, y, s);

    // Stall mid-RUN for 5 cycles.
    send(24'h2ABCDE, 0, 2, 5, y, s);
    send(24'hF13579, 1, 6, 3, y, s);

    // Random coefficients and samples with random backpressure and stalls.
    for (int k = 0; k < DEPTH; k++) rom[k] = DW'($urandom);
    for (int i = 0; i < 30; i++) begin
      if (i == 15) for (int k = 0; k < DEPTH; k++) rom[k] = DW'($urandom);
      if ($urandom_range(2) == 0)
        send(DW'($urandom), int'($urandom_range(3)), int'($urandom_range(7, 1)),
             int'($urandom_range(4, 1)), y, s);
      else
        send(DW'($urandom), int'($urandom_range(3)), 0, 0, y, s);
    end

    // Reset mid-RUN clears history; next impulse sees only itself.
    iv_din = 24'h654321;
    i_din_valid = 1'b1;
    step();
    i_din_valid = 1'b0;
    step();
    step();
    i_rst = 1'b1;
    #1;
    check("mid_rst_dout", ov_dout, 0);
    check("mid_rst_sat", o_dout_sat, 0);
    check("mid_rst_valid", o_dout_valid, 0);
    check("mid_rst_din_ready", o_din_ready, 0);
    check("mid_rst_coef_addr", ov_coef_addr, 0);
    check("mid_rst_coef_en", o_coef_en, 0);
    clear_hist();
    step();
    i_rst = 1'b0;
    step();
    rom[0] = 24'h400000; rom[1] = 24'h200000; rom[2] = 24'h100000; rom[3] = 24'h080000;
    send(24'h400000, 0, 0, 0, y, s);
    check("post_rst_impulse", y, 24'h200000);
    check("post_rst_sat", s, 0);
    send(24'h000000, 0, 0, 0, y, s);
    check("post_rst_tap1", y, 24'h100000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
